// File: rtl/dot_acc_8b_pkg.sv
// Shared types and widths for the 8-bit dot-product accumulator.
package dot_acc_8b_pkg;
  localparam int OP_W  = 8;
  localparam int ACC_W = 16;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;
endpackage

// File: rtl/dot_acc_8b_if.sv
// Operand stream in, result stream out; both val/rdy.
interface dot_acc_8b_if
  import dot_acc_8b_pkg::*;
#(
  parameter int p_count_nbits = 8
);
  logic                     in_val;
  logic                     in_rdy;
  logic [OP_W-1:0]          in_a;
  logic [OP_W-1:0]          in_b;
  logic                     in_last;
  logic                     out_val;
  logic                     out_rdy;
  logic [ACC_W-1:0]         out_sum;
  logic [p_count_nbits-1:0] out_count;
  logic                     out_ovf;

  modport master (
    output in_val, in_a, in_b, in_last, out_rdy,
    input  in_rdy, out_val, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_val, in_a, in_b, in_last, out_rdy,
    output in_rdy, out_val, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/dot_acc_8b_madd_8b_c17.sv
// Combinational 8x8 multiply plus 16-bit addend, 17-bit exact result.
module madd_8b_c17
  import dot_acc_8b_pkg::*;
(
  input  logic [OP_W-1:0]  in0,
  input  logic [OP_W-1:0]  in1,
  input  logic [ACC_W-1:0] in2,
  output logic [ACC_W:0]   out17
);
  logic [ACC_W-1:0] prod;

  // 255*255 fits in 16 bits, so the product never loses bits
  assign prod  = ACC_W'(in0) * ACC_W'(in1);
  assign out17 = (ACC_W+1)'(prod) + (ACC_W+1)'(in2);
endmodule

// File: rtl/dot_acc_8b.sv
// Dot-product accumulator: sums a*b per vector, presents sum/count/ovf on last.
module dot_acc_8b
  import dot_acc_8b_pkg::*;
#(
  parameter int p_count_nbits = 8
) (
  input logic         clk,
  input logic         reset,
  dot_acc_8b_if.slave bus
);
  state_t                   state, state_nx;
  logic [ACC_W-1:0]         acc;
  logic [p_count_nbits-1:0] cnt;
  logic                     ovf;
  logic [ACC_W:0]           sum17;
  logic                     in_rdy, out_val;
  logic                     in_fire, out_fire;

  madd_8b_c17 u_madd (
    .in0   (bus.in_a),
    .in1   (bus.in_b),
    .in2   (acc),
    .out17 (sum17)
  );

  assign in_fire  = bus.in_val & in_rdy;
  assign out_fire = out_val & bus.out_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ACC;
    else       state <= state_nx;
  end

  // Next state: close the vector on last, reopen once the result is taken
  always_comb begin
    state_nx = state;
    case (state)
      ACC:     if (in_fire && bus.in_last) state_nx = DONE;
      DONE:    if (out_fire)               state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  // Handshake outputs decoded from state; no input/output bypass
  always_comb begin
    in_rdy  = (state == ACC);
    out_val = (state == DONE);
  end

  // Accumulator, element counter and sticky carry flag
  always_ff @(posedge clk) begin
    if (reset || out_fire) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (in_fire) begin
      acc <= sum17[ACC_W-1:0];
      cnt <= cnt + p_count_nbits'(1);
      ovf <= ovf | sum17[ACC_W];
    end
  end

  assign bus.in_rdy    = in_rdy;
  assign bus.out_val   = out_val;
  assign bus.out_sum   = acc;
  assign bus.out_count = cnt;
  assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_dot_acc_8b.sv
// Bench: two instances (8-bit and 2-bit counters) driven identically and
// compared against a plain-arithmetic vector model.
module tb_dot_acc_8b;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  int   va[$];
  int   vb[$];

  dot_acc_8b_if #(.p_count_nbits(8)) bus8 ();
  dot_acc_8b_if #(.p_count_nbits(2)) bus2 ();

  dot_acc_8b #(.p_count_nbits(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  dot_acc_8b #(.p_count_nbits(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(bit v, int a, int b, bit l);
    bus8.in_val = v; bus8.in_a = a[7:0]; bus8.in_b = b[7:0]; bus8.in_last = l;
    bus2.in_val = v; bus2.in_a = a[7:0]; bus2.in_b = b[7:0]; bus2.in_last = l;
  endtask

  task automatic set_out_rdy(bit r);
    bus8.out_rdy = r;
    bus2.out_rdy = r;
  endtask

  // Checks both instances against one expected result (count reduced per width)
  task automatic check_out(string tag, bit vld, int sum, int cnt, bit ovf);
    chk({tag, ".val8"},  bus8.out_val,   vld);
    chk({tag, ".rdy8"},  bus8.in_rdy,    !vld);
    chk({tag, ".sum8"},  bus8.out_sum,   sum % 65536);
    chk({tag, ".cnt8"},  bus8.out_count, cnt % 256);
    chk({tag, ".ovf8"},  bus8.out_ovf,   ovf);
    chk({tag, ".val2"},  bus2.out_val,   vld);
    chk({tag, ".sum2"},  bus2.out_sum,   sum % 65536);
    chk({tag, ".cnt2"},  bus2.out_count, cnt % 4);
    chk({tag, ".ovf2"},  bus2.out_ovf,   ovf);
  endtask

  // Sends va/vb as one vector, checks the result, holds it for `hold`
  // cycles of backpressure, then takes it and checks the cleared state.
  task automatic run_vec(string tag, int hold, bit gaps);
    longint tot = 0;
    int     n   = va.size();
    for (int i = 0; i < n; i++) tot += longint'(va[i]) * longint'(vb[i]);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        drive_in(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        tick();
      end
      drive_in(1'b1, va[i], vb[i], i == n - 1);
      tick();
    end
    drive_in(1'b0, 0, 0, 1'b0);
    check_out(tag, 1'b1, int'(tot % 65536), n, tot >= 65536);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_out({tag, ".hold"}, 1'b1, int'(tot % 65536), n, tot >= 65536);
    end
    set_out_rdy(1'b1);
    tick();
    set_out_rdy(1'b0);
    check_out({tag, ".clr"}, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive_in(1'b0, 0, 0, 1'b0);
    set_out_rdy(1'b0);
    tick(); tick();
    reset = 1'b0;
    check_out("reset", 1'b0, 0, 0, 1'b0);

    // idle: in_val low with junk data must not disturb anything
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
      tick();
      check_out("idle", 1'b0, 0, 0, 1'b0);
    end

    va = '{2};      vb = '{3};      run_vec("single", 0, 1'b0);
    va = '{1, 3, 5}; vb = '{2, 4, 6}; run_vec("vec3", 1, 1'b0);
    va = '{7};      vb = '{8};      run_vec("vec7x8", 0, 1'b0);
    va = '{255, 255}; vb = '{255, 255}; run_vec("ovf", 0, 1'b0);
    va = '{1};      vb = '{1};      run_vec("ovfclr", 0, 1'b0);

    // backpressure with a pending pair presented the whole time
    drive_in(1'b1, 10, 10, 1'b1);
    tick();
    drive_in(1'b1, 9, 9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_out("bp.hold", 1'b1, 100, 1, 1'b0);
      tick();
    end
    check_out("bp.hold", 1'b1, 100, 1, 1'b0);
    set_out_rdy(1'b1);
    tick();
    set_out_rdy(1'b0);
    check_out("bp.release", 1'b0, 0, 0, 1'b0);
    tick();
    drive_in(1'b0, 0, 0, 1'b0);
    check_out("bp.next", 1'b1, 81, 1, 1'b0);
    set_out_rdy(1'b1);
    tick();
    set_out_rdy(1'b0);

    // reset mid-vector, with a firing pair present during reset
    drive_in(1'b1, 20, 20, 1'b0); tick();
    drive_in(1'b1, 30, 30, 1'b0); tick();
    reset = 1'b1;
    drive_in(1'b1, 40, 40, 1'b1); tick();
    reset = 1'b0;
    drive_in(1'b0, 0, 0, 1'b0);
    check_out("rst.mid", 1'b0, 0, 0, 1'b0);
    va = '{2}; vb = '{2}; run_vec("rst.after", 0, 1'b0);

    // 5-element vector wraps the 2-bit counter to 1
    va.delete(); vb.delete();
    for (int i = 0; i < 5; i++) begin
      va.push_back($urandom_range(0, 255));
      vb.push_back($urandom_range(0, 255));
    end
    run_vec("wrap5", 0, 1'b0);

    // random vectors: random lengths, gaps and backpressure
    for (int v = 0; v < 25; v++) begin
      int len = $urandom_range(1, 9);
      va.delete(); vb.delete();
      for (int i = 0; i < len; i++) begin
        va.push_back($urandom_range(0, 3) == 0 ? 255 : $urandom_range(0, 255));
        vb.push_back($urandom_range(0, 3) == 0 ? 255 : $urandom_range(0, 255));
      end
      run_vec("rand", $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
